upgrade_scheduler: RTL and testbench

Frame-rate controller for the single bullet-upgrade pickup. It decides when and where the pickup appears and how long it stays on screen. It holds the upgrade collision detector cleared while the pickup is hidden and latches which player collected it. It then times that player's powered-bullet window. It sits between the game-state logic and the upgrade collision detector, and it drives the pickup sprite position and both players' bullet-upgrade enables.

---
 rtl/upgrade_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_upgrade_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/upgrade_scheduler.sv
// upgrade_scheduler
// Frame-rate controller for the single bullet-upgrade pickup.
//   - Hides the pickup for SPAWN_DELAY frames, shows it at a pseudo-random
//     site for up to LIFETIME frames, then grants POWER_DURATION frames of
//     upgraded bullets to whichever player collected it.
// Ports:
//   frame_clk          : one rising edge per video frame (only clock)
//   Reset              : synchronous, active-high
//   game_enable        : round in progress; low forces the hidden state
//   bullet_1/2_upgraded: latched collect flags from the collision detector
//   player_hit_1/2     : one-frame hit pulses
//   upgrade_clear      : holds the collision detector cleared while hidden
//   upgrade_visible    : pickup sprite enable
//   UpgradeX/UpgradeY  : current site coordinates (shown even while hidden)
//   power_1/power_2    : per-player upgraded-bullet enables
//   power_remaining    : frames left in the powered window, 0 otherwise
module upgrade_scheduler #(
  parameter int unsigned SPAWN_DELAY    = 300,
  parameter int unsigned LIFETIME       = 600,
  parameter int unsigned POWER_DURATION = 480,
  parameter logic [39:0] SITE_X = {10'd120, 10'd520, 10'd320, 10'd320},
  parameter logic [39:0] SITE_Y = {10'd240, 10'd240, 10'd80, 10'd400}
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        game_enable,
  input  logic        bullet_1_upgraded,
  input  logic        bullet_2_upgraded,
  input  logic        player_hit_1,
  input  logic        player_hit_2,
  output logic        upgrade_clear,
  output logic        upgrade_visible,
  output logic [9:0]  UpgradeX,
  output logic [9:0]  UpgradeY,
  output logic        power_1,
  output logic        power_2,
  output logic [11:0] power_remaining
);

  localparam logic [11:0] SPAWN_LD = 12'(SPAWN_DELAY);
  localparam logic [11:0] LIFE_LD  = 12'(LIFETIME);
  localparam logic [11:0] POWER_LD = 12'(POWER_DURATION);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    POWERED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [1:0]  site_q, site_d;
  logic [1:0]  owner_q, owner_d;   // 0 = nobody, 1 = player 1, 2 = player 2
  logic [7:0]  lfsr_q, lfsr_d;

  logic        upgrade_clear_q, upgrade_clear_d;
  logic        upgrade_visible_q, upgrade_visible_d;
  logic        power_1_q, power_1_d;
  logic        power_2_q, power_2_d;
  logic [11:0] power_remaining_q, power_remaining_d;

  logic [1:0]  pick;
  logic        owner_hit;

  // Unpack the site tables so the coordinates are a plain array lookup.
  logic [9:0] site_x_tab [4];
  logic [9:0] site_y_tab [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_site
      assign site_x_tab[gi] = SITE_X[gi*10 +: 10];
      assign site_y_tab[gi] = SITE_Y[gi*10 +: 10];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    site_d  = site_q;
    owner_d = owner_q;
    // Fibonacci LFSR, taps 8,6,5,4; free-runs every frame in every state.
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Never respawn on the same site twice in a row: bump to the next one.
    pick = lfsr_q[1:0];
    if (pick == site_q) begin
      pick = pick + 2'd1;
    end

    owner_hit = (owner_q == 2'd1) ? player_hit_1 : player_hit_2;

    if (!game_enable) begin
      state_d = IDLE;
      cnt_d   = SPAWN_LD;
    end else begin
      case (state_q)
        IDLE: begin
          if (cnt_q == 12'd1) begin
            state_d = ACTIVE;
            cnt_d   = LIFE_LD;
            site_d  = pick;
          end else begin
            cnt_d = cnt_q - 12'd1;
          end
        end
        ACTIVE: begin
          // Collection outranks expiry on the same frame.
          if (bullet_1_upgraded) begin
            state_d = POWERED;
            owner_d = 2'd1;
            cnt_d   = POWER_LD;
          end else if (bullet_2_upgraded) begin
            state_d = POWERED;
            owner_d = 2'd2;
            cnt_d   = POWER_LD;
          end else if (cnt_q == 12'd1) begin
            state_d = IDLE;
            cnt_d   = SPAWN_LD;
          end else begin
            cnt_d = cnt_q - 12'd1;
          end
        end
        POWERED: begin
          if (owner_hit || (cnt_q == 12'd1)) begin
            state_d = IDLE;
            cnt_d   = SPAWN_LD;
          end else begin
            cnt_d = cnt_q - 12'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = SPAWN_LD;
        end
      endcase
    end

    // Outputs are decoded from the next state so they flip on the same
    // edge as the state register.
    upgrade_clear_d   = (state_d == IDLE);
    upgrade_visible_d = (state_d == ACTIVE);
    power_1_d         = (state_d == POWERED) && (owner_d == 2'd1);
    power_2_d         = (state_d == POWERED) && (owner_d == 2'd2);
    power_remaining_d = (state_d == POWERED) ? cnt_d : 12'd0;
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q           <= IDLE;
      cnt_q             <= SPAWN_LD;
      site_q            <= 2'd0;
      owner_q           <= 2'd0;
      lfsr_q            <= 8'h5A;
      upgrade_clear_q   <= 1'b1;
      upgrade_visible_q <= 1'b0;
      power_1_q         <= 1'b0;
      power_2_q         <= 1'b0;
      power_remaining_q <= 12'd0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      site_q            <= site_d;
      owner_q           <= owner_d;
      lfsr_q            <= lfsr_d;
      upgrade_clear_q   <= upgrade_clear_d;
      upgrade_visible_q <= upgrade_visible_d;
      power_1_q         <= power_1_d;
      power_2_q         <= power_2_d;
      power_remaining_q <= power_remaining_d;
    end
  end

  assign upgrade_clear   = upgrade_clear_q;
  assign upgrade_visible = upgrade_visible_q;
  assign power_1         = power_1_q;
  assign power_2         = power_2_q;
  assign power_remaining = power_remaining_q;
  assign UpgradeX        = site_x_tab[site_q];
  assign UpgradeY        = site_y_tab[site_q];

endmodule

// File: tb/tb_upgrade_scheduler.sv
// Testbench for upgrade_scheduler: directed steps followed by randomized
// traffic, all checked against a frame-level behavioural model.
module tb_upgrade_scheduler;

  localparam int SD = 3;
  localparam int LT = 4;
  localparam int PD = 5;
  localparam logic [39:0] SX = {10'd120, 10'd520, 10'd320, 10'd320};
  localparam logic [39:0] SY = {10'd240, 10'd240, 10'd80, 10'd400};

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b1;
  logic        game_enable = 1'b0;
  logic        bullet_1_upgraded = 1'b0;
  logic        bullet_2_upgraded = 1'b0;
  logic        player_hit_1 = 1'b0;
  logic        player_hit_2 = 1'b0;
  logic        upgrade_clear;
  logic        upgrade_visible;
  logic [9:0]  UpgradeX;
  logic [9:0]  UpgradeY;
  logic        power_1;
  logic        power_2;
  logic [11:0] power_remaining;

  always #5 frame_clk = ~frame_clk;

  upgrade_scheduler #(
    .SPAWN_DELAY(SD), .LIFETIME(LT), .POWER_DURATION(PD),
    .SITE_X(SX), .SITE_Y(SY)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .game_enable(game_enable),
    .bullet_1_upgraded(bullet_1_upgraded), .bullet_2_upgraded(bullet_2_upgraded),
    .player_hit_1(player_hit_1), .player_hit_2(player_hit_2),
    .upgrade_clear(upgrade_clear), .upgrade_visible(upgrade_visible),
    .UpgradeX(UpgradeX), .UpgradeY(UpgradeY),
    .power_1(power_1), .power_2(power_2), .power_remaining(power_remaining)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Site coordinates as the game sees them (entry 0 first).
  int xt [4] = '{320, 320, 520, 120};
  int yt [4] = '{400, 80, 240, 240};

  // Model: phase 0 = hidden, 1 = shown, 2 = powered.
  int m_phase = 0;
  int m_left  = SD;
  int m_site  = 0;
  int m_owner = 0;
  int m_lfsr  = 'h5A;

  task automatic model_edge();
    int fb;
    int idx;
    if (Reset) begin
      m_phase = 0; m_left = SD; m_site = 0; m_owner = 0; m_lfsr = 'h5A;
      return;
    end
    fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
    if (!game_enable) begin
      m_phase = 0; m_left = SD;
    end else if (m_phase == 0) begin
      if (m_left == 1) begin
        idx = m_lfsr % 4;
        if (idx == m_site) idx = (idx + 1) % 4;
        m_site = idx; m_phase = 1; m_left = LT;
      end else m_left--;
    end else if (m_phase == 1) begin
      if (bullet_1_upgraded) begin
        m_phase = 2; m_owner = 1; m_left = PD;
      end else if (bullet_2_upgraded) begin
        m_phase = 2; m_owner = 2; m_left = PD;
      end else if (m_left == 1) begin
        m_phase = 0; m_left = SD;
      end else m_left--;
    end else begin
      if (((m_owner == 1) ? player_hit_1 : player_hit_2) || m_left == 1) begin
        m_phase = 0; m_left = SD;
      end else m_left--;
    end
    m_lfsr = ((m_lfsr << 1) | fb) & 'hFF;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    check("clear",   32'(upgrade_clear),   32'(m_phase == 0));
    check("visible", 32'(upgrade_visible), 32'(m_phase == 1));
    check("power_1", 32'(power_1),         32'(m_phase == 2 && m_owner == 1));
    check("power_2", 32'(power_2),         32'(m_phase == 2 && m_owner == 2));
    check("remain",  32'(power_remaining), (m_phase == 2) ? 32'(m_left) : 32'd0);
    check("site_x",  32'(UpgradeX),        32'(xt[m_site]));
    check("site_y",  32'(UpgradeY),        32'(yt[m_site]));
  endtask

  task automatic cycle(input logic r, input logic e, input logic b1, input logic b2,
                       input logic h1, input logic h2);
    Reset = r; game_enable = e;
    bullet_1_upgraded = b1; bullet_2_upgraded = b2;
    player_hit_1 = h1; player_hit_2 = h2;
    @(posedge frame_clk);
    model_edge();
    #1;
    cyc++;
    $display("[TB] cyc=%0d rst=%0b en=%0b b=%0b%0b h=%0b%0b | clr=%0b vis=%0b p=%0b%0b rem=%0d xy=%0d,%0d",
             cyc, r, e, b1, b2, h1, h2, upgrade_clear, upgrade_visible,
             power_1, power_2, power_remaining, UpgradeX, UpgradeY);
    check_all();
  endtask

  task automatic wait_active();
    int n;
    n = 0;
    while (m_phase != 1 && n < 20) begin
      cycle(0, 1, 0, 0, 0, 0);
      n++;
    end
    if (m_phase != 1) begin
      tests++; fails++;
      $error("FAIL wait_active timed out observed_phase=%0d required=1", m_phase);
    end
  endtask

  function automatic int decode_site(input logic [9:0] x, input logic [9:0] y);
    for (int i = 0; i < 4; i++)
      if (int'(x) == xt[i] && int'(y) == yt[i]) return i;
    return -1;
  endfunction

  initial begin
    int spawns;
    int prev_idx;
    int cur_idx;
    int guard;
    int was_phase;

    // Reset state.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check("rst_clear_c",   32'(upgrade_clear),   32'd1);
    check("rst_visible_c", 32'(upgrade_visible), 32'd0);
    check("rst_remain_c",  32'(power_remaining), 32'd0);
    check("rst_x_c",       32'(UpgradeX),        32'd320);
    check("rst_y_c",       32'(UpgradeY),        32'd400);

    // First spawn after SD edges, visible for exactly LT frames.
    for (int e = 1; e <= 7; e++) begin
      cycle(0, 1, 0, 0, 0, 0);
      if (e < 3) check("idle_clear_c", 32'(upgrade_clear), 32'd1);
      if (e == 3) begin
        check("spawn_vis_c", 32'(upgrade_visible), 32'd1);
        check("spawn_clear_c", 32'(upgrade_clear), 32'd0);
        check("first_site_not0", 32'(decode_site(UpgradeX, UpgradeY) == 0), 32'd0);
      end
      if (e == 6) check("last_vis_c", 32'(upgrade_visible), 32'd1);
      if (e == 7) check("expire_vis_c", 32'(upgrade_visible), 32'd0);
    end

    // Both collect flags together: player 1 wins; full powered window.
    wait_active();
    cycle(0, 1, 1, 1, 0, 0);
    check("both_p1_c",  32'(power_1), 32'd1);
    check("both_p2_c",  32'(power_2), 32'd0);
    check("both_rem_c", 32'(power_remaining), 32'(PD));
    for (int k = 1; k < PD; k++) begin
      cycle(0, 1, 1, 1, 0, 0);
      check("count_rem_c", 32'(power_remaining), 32'(PD - k));
      check("count_p1_c",  32'(power_1), 32'd1);
    end
    cycle(0, 1, 0, 0, 0, 0);
    check("window_end_p1_c", 32'(power_1), 32'd0);
    check("window_end_clr_c", 32'(upgrade_clear), 32'd1);

    // Collection on the expiry frame: collection wins, owner 2.
    wait_active();
    for (int k = 1; k < LT; k++) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 0, 0);
    check("late_p2_c",  32'(power_2), 32'd1);
    check("late_vis_c", 32'(upgrade_visible), 32'd0);
    check("late_rem_c", 32'(power_remaining), 32'(PD));
    cycle(0, 1, 0, 0, 1, 0);
    check("nonowner_p2_c", 32'(power_2), 32'd1);
    cycle(0, 1, 0, 0, 0, 1);
    check("owner2_hit_c", 32'(power_2), 32'd0);

    // Owner 1: non-owner hit ignored, owner hit ends window early.
    wait_active();
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 1);
    check("ignore_hit2_c", 32'(power_1), 32'd1);
    check("ignore_hit2_rem_c", 32'(power_remaining), 32'(PD - 1));
    cycle(0, 1, 0, 0, 1, 0);
    check("hit1_p1_c",  32'(power_1), 32'd0);
    check("hit1_clr_c", 32'(upgrade_clear), 32'd1);
    check("hit1_rem_c", 32'(power_remaining), 32'd0);
    for (int k = 1; k <= SD; k++) begin
      cycle(0, 1, 0, 0, 0, 0);
      check("respawn_delay_c", 32'(upgrade_visible), 32'(k == SD));
    end

    // game_enable dropped while powered.
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("dis_clear_c", 32'(upgrade_clear), 32'd1);
    check("dis_p1_c",    32'(power_1), 32'd0);
    check("dis_rem_c",   32'(power_remaining), 32'd0);

    // Reset while active: site returns to entry 0.
    wait_active();
    cycle(1, 1, 0, 0, 0, 0);
    check("rst_act_clear_c", 32'(upgrade_clear), 32'd1);
    check("rst_act_vis_c",   32'(upgrade_visible), 32'd0);
    check("rst_act_x_c",     32'(UpgradeX), 32'd320);
    check("rst_act_y_c",     32'(UpgradeY), 32'd400);

    // Randomized traffic until 50 spawns have been observed.
    spawns = 0;
    guard  = 0;
    while (spawns < 50 && guard < 4000) begin
      prev_idx  = decode_site(UpgradeX, UpgradeY);
      was_phase = m_phase;
      cycle(($urandom % 256) == 0, ($urandom % 64) != 0,
            ($urandom % 6) == 0, ($urandom % 6) == 0,
            ($urandom % 8) == 0, ($urandom % 8) == 0);
      if (was_phase == 0 && m_phase == 1) begin
        cur_idx = decode_site(UpgradeX, UpgradeY);
        tests++;
        assert (cur_idx != prev_idx && cur_idx >= 0) else begin
          fails++;
          $error("FAIL site_repeat observed=%0d required_not=%0d", cur_idx, prev_idx);
        end
        spawns++;
      end
      guard++;
    end
    if (spawns < 50) begin
      tests++; fails++;
      $error("FAIL spawn_budget observed=%0d required=50", spawns);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
